// File: rtl/key_extractor_pkg.sv
// Shared constants for the key extractor: header-absent marker, field width
// codes and the width-legality helper used by both extractor and aligner.
package key_extractor_pkg;

  localparam logic [31:0] NO_HEADER = 32'hFFFF_FFFF;

  localparam logic [3:0] W_BYTE = 4'd1;
  localparam logic [3:0] W_HALF = 4'd2;
  localparam logic [3:0] W_WORD = 4'd4;

  function automatic logic width_legal(input logic [3:0] w);
    return (w == W_BYTE) || (w == W_HALF) || (w == W_WORD);
  endfunction

endpackage

// File: rtl/key_extractor_field_align.sv
// Zero-extends the low 1, 2 or 4 bytes of a memory word according to a
// width code; any other code yields zero. Shared with the deparser.
module key_extractor_field_align
  import key_extractor_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        width_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  // Width-code driven zero-extension.
  always_comb begin
    data_o = '0;
    case (width_i)
      W_BYTE:  data_o = DATA_W'(data_i[7:0]);
      W_HALF:  data_o = DATA_W'(data_i[15:0]);
      W_WORD:  data_o = DATA_W'(data_i[31:0]);
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/key_extractor.sv
// Match-key extractor: on parser ready, latches header bases and walks the
// slot table, issuing one memory read per cycle and assembling the key.
module key_extractor
  import key_extractor_pkg::*;
#(
  parameter int NUM_HEADERS = 2,
  parameter int NUM_FIELDS  = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ready_i,
  input  logic [NUM_HEADERS-1:0][DATA_W-1:0]    parsed_hdrs_i,
  output logic                                  mem_ce_o,
  output logic                                  mem_we_o,
  output logic [ADDR_W-1:0]                     mem_addr_o,
  output logic [3:0]                            mem_width_o,
  output logic [DATA_W-1:0]                     mem_data_o,
  input  logic [DATA_W-1:0]                     mem_data_i,
  output logic [DATA_W*NUM_FIELDS-1:0]          key_o,
  output logic [NUM_FIELDS-1:0]                 key_mask_o,
  output logic                                  key_valid_o,
  input  logic                                  key_ready_i,
  input  logic                                  mod_start_i,
  input  logic [DATA_W-1:0]                     mod_slot_i,
  input  logic [DATA_W-1:0]                     mod_hdr_id_i,
  input  logic [DATA_W-1:0]                     mod_offset_i,
  input  logic [3:0]                            mod_width_i
);

  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hdr_id;
    logic [DATA_W-1:0] offset;
    logic [3:0]        width;
  } slot_cfg_t;

  state_e                               state_q, state_d;
  slot_cfg_t [NUM_FIELDS-1:0]           cfg_q, cfg_d;
  logic [NUM_HEADERS-1:0][DATA_W-1:0]   bases_q, bases_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic                                 mem_ce_q, mem_ce_d;
  logic [ADDR_W-1:0]                    mem_addr_q, mem_addr_d;
  logic [3:0]                           mem_width_q, mem_width_d;
  logic [NUM_FIELDS-1:0][DATA_W-1:0]    key_q, key_d;
  logic [NUM_FIELDS-1:0]                key_mask_q, key_mask_d;
  logic                                 key_valid_q, key_valid_d;

  logic [IDX_W-1:0]                     req_slot_s;
  logic [NUM_HEADERS-1:0][DATA_W-1:0]   req_bases_s;
  slot_cfg_t                            req_cfg_s;
  logic [DATA_W-1:0]                    req_base_s;
  logic                                 req_hdr_ok_s;
  logic                                 req_active_s;
  logic [ADDR_W-1:0]                    req_addr_s;
  logic [DATA_W-1:0]                    aligned_s;
  logic                                 last_s;

  // The slot-0 request is built from the live parser bases; later ones use the latched copy.
  always_comb begin
    req_slot_s   = (state_q == IDLE) ? '0 : idx_q + IDX_W'(1);
    req_bases_s  = (state_q == IDLE) ? parsed_hdrs_i : bases_q;
    req_cfg_s    = cfg_q[req_slot_s];
    req_base_s   = '0;
    req_hdr_ok_s = 1'b0;
    for (int h = 0; h < NUM_HEADERS; h++) begin
      req_hdr_ok_s = req_hdr_ok_s | (req_cfg_s.hdr_id == DATA_W'(h));
      req_base_s   = req_base_s | ((req_cfg_s.hdr_id == DATA_W'(h)) ? req_bases_s[h] : '0);
    end
    req_active_s = width_legal(req_cfg_s.width) && req_hdr_ok_s &&
                   (req_base_s != DATA_W'(NO_HEADER));
    req_addr_s   = req_active_s ? (ADDR_W'(req_base_s) + ADDR_W'(req_cfg_s.offset)) : '0;
    last_s       = (idx_q == IDX_W'(NUM_FIELDS - 1));
  end

  key_extractor_field_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .width_i (mem_width_q),
    .data_i  (mem_data_i),
    .data_o  (aligned_s)
  );

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      bases_q     <= '0;
      idx_q       <= '0;
      mem_ce_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_width_q <= 4'd0;
      key_q       <= '0;
      key_mask_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      bases_q     <= bases_d;
      idx_q       <= idx_d;
      mem_ce_q    <= mem_ce_d;
      mem_addr_q  <= mem_addr_d;
      mem_width_q <= mem_width_d;
      key_q       <= key_d;
      key_mask_q  <= key_mask_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Next-state logic; a table write in IDLE defers the start by one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mod_start_i) begin
          state_d = IDLE;
        end else if (ready_i) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH:    state_d = last_s ? DONE : FETCH;
      DONE:     state_d = key_ready_i ? WAIT_LOW : DONE;
      WAIT_LOW: state_d = ready_i ? WAIT_LOW : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath updates: table writes, request issue, key capture and handshake.
  always_comb begin
    cfg_d       = cfg_q;
    bases_d     = bases_q;
    idx_d       = idx_q;
    mem_ce_d    = mem_ce_q;
    mem_addr_d  = mem_addr_q;
    mem_width_d = mem_width_q;
    key_d       = key_q;
    key_mask_d  = key_mask_q;
    key_valid_d = key_valid_q;
    case (state_q)
      IDLE: begin
        if (mod_start_i) begin
          if (mod_slot_i < DATA_W'(NUM_FIELDS)) begin
            cfg_d[mod_slot_i[IDX_W-1:0]].hdr_id = mod_hdr_id_i;
            cfg_d[mod_slot_i[IDX_W-1:0]].offset = mod_offset_i;
            cfg_d[mod_slot_i[IDX_W-1:0]].width  = mod_width_i;
          end else begin
            cfg_d = cfg_q;
          end
        end else if (ready_i) begin
          bases_d     = parsed_hdrs_i;
          key_d       = '0;
          key_mask_d  = '0;
          idx_d       = '0;
          mem_ce_d    = req_active_s;
          mem_addr_d  = req_addr_s;
          mem_width_d = req_active_s ? req_cfg_s.width : 4'd0;
        end else begin
          idx_d = idx_q;
        end
      end
      FETCH: begin
        if (mem_ce_q) begin
          key_d[idx_q]      = aligned_s;
          key_mask_d[idx_q] = 1'b1;
        end else begin
          key_d[idx_q]      = '0;
        end
        if (!last_s) begin
          idx_d       = idx_q + IDX_W'(1);
          mem_ce_d    = req_active_s;
          mem_addr_d  = req_addr_s;
          mem_width_d = req_active_s ? req_cfg_s.width : 4'd0;
        end else begin
          mem_ce_d    = 1'b0;
          mem_addr_d  = '0;
          mem_width_d = 4'd0;
          key_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (key_ready_i) begin
          key_valid_d = 1'b0;
        end else begin
          key_valid_d = 1'b1;
        end
      end
      WAIT_LOW: key_valid_d = 1'b0;
      default:  key_valid_d = 1'b0;
    endcase
  end

  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = 1'b0;
  assign mem_addr_o  = mem_addr_q;
  assign mem_width_o = mem_width_q;
  assign mem_data_o  = '0;
  assign key_o       = key_q;
  assign key_mask_o  = key_mask_q;
  assign key_valid_o = key_valid_q;

endmodule

// File: tb/tb_key_extractor.sv
// Scoreboard bench for key_extractor: expected keys are computed from a
// shadow slot table when a packet starts and compared when key_valid_o rises.
module tb_key_extractor;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   mask;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               ready_i;
  logic [1:0][31:0]   parsed_hdrs_i;
  logic               mem_ce_o;
  logic               mem_we_o;
  logic [31:0]        mem_addr_o;
  logic [3:0]         mem_width_o;
  logic [31:0]        mem_data_o;
  logic [31:0]        mem_data_i;
  logic [127:0]       key_o;
  logic [3:0]         key_mask_o;
  logic               key_valid_o;
  logic               key_ready_i;
  logic               mod_start_i;
  logic [31:0]        mod_slot_i;
  logic [31:0]        mod_hdr_id_i;
  logic [31:0]        mod_offset_i;
  logic [3:0]         mod_width_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  logic        prev_valid = 1'b0;

  logic [31:0] m_hdr [4];
  logic [31:0] m_off [4];
  logic [3:0]  m_w   [4];

  always #5 clk = ~clk;

  key_extractor dut (
    .clk           (clk),
    .rst           (rst),
    .ready_i       (ready_i),
    .parsed_hdrs_i (parsed_hdrs_i),
    .mem_ce_o      (mem_ce_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_width_o   (mem_width_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .key_o         (key_o),
    .key_mask_o    (key_mask_o),
    .key_valid_o   (key_valid_o),
    .key_ready_i   (key_ready_i),
    .mod_start_i   (mod_start_i),
    .mod_slot_i    (mod_slot_i),
    .mod_hdr_id_i  (mod_hdr_id_i),
    .mod_offset_i  (mod_offset_i),
    .mod_width_i   (mod_width_i)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[7:0] ^ 8'hC3, a[15:8] + 8'h21, ~a[7:0], a[7:0] + 8'h5A};
  endfunction

  assign mem_data_i = mem_fn(mem_addr_o);

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop and compare on each rising key_valid_o.
  always @(negedge clk) begin
    if (key_valid_o && !prev_valid) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_key", 128'(1), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_key", key_o, e.key);
        check_eq("sb_mask", 128'(key_mask_o), 128'(e.mask));
      end
    end
    prev_valid <= key_valid_o;
  end

  task automatic write_cfg(input int slot, input logic [31:0] hdr, input logic [31:0] off,
                           input logic [3:0] w);
    mod_start_i  = 1'b1;
    mod_slot_i   = 32'(slot);
    mod_hdr_id_i = hdr;
    mod_offset_i = off;
    mod_width_i  = w;
    @(negedge clk);
    mod_start_i = 1'b0;
    if (slot < 4) begin
      m_hdr[slot] = hdr;
      m_off[slot] = off;
      m_w[slot]   = w;
    end
    check_eq("cfg_idle_ce", 128'(mem_ce_o), 128'(0));
  endtask

  task automatic run_packet(input logic [31:0] h0, input logic [31:0] h1, input int hold,
                            input bit mod_mid, input bit drop_ready);
    exp_t         e;
    logic [31:0]  eaddr [4];
    bit           eact  [4];
    logic [31:0]  base, d;
    logic [127:0] snap;
    int           cyc;
    e.key  = '0;
    e.mask = '0;
    for (int k = 0; k < 4; k++) begin
      base    = (m_hdr[k] == 32'd0) ? h0 : h1;
      eact[k] = (m_w[k] == 4'd1 || m_w[k] == 4'd2 || m_w[k] == 4'd4) &&
                (m_hdr[k] < 32'd2) && (base != 32'hFFFF_FFFF);
      eaddr[k] = base + m_off[k];
      d = mem_fn(eaddr[k]);
      if (m_w[k] == 4'd1)      d = d & 32'h0000_00FF;
      else if (m_w[k] == 4'd2) d = d & 32'h0000_FFFF;
      else                     d = d;
      if (eact[k]) begin
        e.key[k*32 +: 32] = d;
        e.mask[k]         = 1'b1;
      end
    end
    sb.push_back(e);
    parsed_hdrs_i = {h1, h0};
    ready_i       = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("ce_slot%0d", k), 128'(mem_ce_o), 128'(eact[k]));
      if (eact[k]) begin
        check_eq($sformatf("addr_slot%0d", k), 128'(mem_addr_o), 128'(eaddr[k]));
        check_eq($sformatf("width_slot%0d", k), 128'(mem_width_o), 128'(m_w[k]));
      end
      check_eq("valid_early", 128'(key_valid_o), 128'(0));
      mod_start_i = mod_mid && (k == 1);
      if (mod_mid && k == 1) begin
        mod_slot_i   = 32'd0;
        mod_hdr_id_i = 32'd1;
        mod_offset_i = 32'h40;
        mod_width_i  = 4'd1;
      end
      if (drop_ready && k == 1) ready_i = 1'b0;
    end
    mod_start_i = 1'b0;
    cyc = 0;
    while (!key_valid_o && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", 128'(cyc + 3), 128'(4));
    check_eq("done_ce", 128'(mem_ce_o), 128'(0));
    snap = key_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_key", key_o, snap);
      check_eq("hold_ce", 128'(mem_ce_o), 128'(0));
      check_eq("hold_valid", 128'(key_valid_o), 128'(1));
    end
    key_ready_i = 1'b1;
    @(negedge clk);
    key_ready_i = 1'b0;
    check_eq("accept_valid", 128'(key_valid_o), 128'(0));
    if (ready_i) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check_eq("wait_low_ce", 128'(mem_ce_o), 128'(0));
        check_eq("wait_low_valid", 128'(key_valid_o), 128'(0));
      end
    end
    ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    ready_i       = 1'b0;
    parsed_hdrs_i = '0;
    key_ready_i   = 1'b0;
    mod_start_i   = 1'b0;
    mod_slot_i    = '0;
    mod_hdr_id_i  = '0;
    mod_offset_i  = '0;
    mod_width_i   = '0;
    for (int k = 0; k < 4; k++) begin
      m_hdr[k] = '0; m_off[k] = '0; m_w[k] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ce", 128'(mem_ce_o), 128'(0));
    check_eq("rst_valid", 128'(key_valid_o), 128'(0));
    check_eq("rst_key", key_o, 128'(0));
    check_eq("rst_mask", 128'(key_mask_o), 128'(0));
    check_eq("rst_we", 128'(mem_we_o), 128'(0));
    rst = 1'b1;
    @(negedge clk);

    // Basic configuration and extraction
    write_cfg(0, 32'd0, 32'd12, 4'd2);
    write_cfg(1, 32'd1, 32'd9,  4'd1);
    write_cfg(2, 32'd0, 32'd0,  4'd0);
    write_cfg(3, 32'd0, 32'd0,  4'd4);
    run_packet(32'h100, 32'h10E, 0, 1'b0, 1'b0);
    // Absent header
    run_packet(32'h100, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    // Backpressure, WAIT_LOW, and a table write attempted mid-fetch
    run_packet(32'h200, 32'h300, 10, 1'b1, 1'b0);
    // Write together with ready: start deferred one cycle, new config used
    ready_i       = 1'b1;
    parsed_hdrs_i = {32'h10E, 32'h100};
    write_cfg(2, 32'd1, 32'd4, 4'd1);
    run_packet(32'h100, 32'h10E, 0, 1'b0, 1'b1);
    // Dropped write, illegal width, address wrap
    write_cfg(7, 32'd0, 32'd8, 4'd1);
    write_cfg(1, 32'd1, 32'd9, 4'd3);
    write_cfg(3, 32'd0, 32'd4, 4'd4);
    run_packet(32'hFFFF_FFFE, 32'h10E, 0, 1'b0, 1'b0);
    // Asynchronous reset mid-fetch
    parsed_hdrs_i = {32'h10E, 32'h100};
    ready_i       = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_ce", 128'(mem_ce_o), 128'(0));
    check_eq("arst_valid", 128'(key_valid_o), 128'(0));
    check_eq("arst_mask", 128'(key_mask_o), 128'(0));
    check_eq("arst_key", key_o, 128'(0));
    check_eq("arst_addr", 128'(mem_addr_o), 128'(0));
    ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_hdr[k] = '0; m_off[k] = '0; m_w[k] = '0;
    end
    @(negedge clk);
    run_packet(32'h100, 32'h10E, 0, 1'b0, 1'b0);
    check_eq("sb_drained", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
